// File: rtl/imem_boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Holds the FSM state encoding, the fetch boot vector and the default imem depth.
package imem_boot_pkg;

  localparam logic [31:0] BOOT_PC    = 32'h0040_0000;
  localparam int          IMEM_DEPTH = 4096;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FLUSH,
    CHECK,
    RUN,
    ERROR
  } state_t;

endpackage

// File: rtl/imem_boot_loader.sv
// Boot loader: streams 32-bit words into imem via the fetch init port, then releases the core.
// Optional IMEM_CHECKSUM_EN adds expected_sum and a CHECK state comparing a running word sum.
module imem_boot_loader
  import imem_boot_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = IMEM_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   length,
`ifdef IMEM_CHECKSUM_EN
  input  logic [31:0]       expected_sum,
`endif
  input  logic              s_valid,
  input  logic [31:0]       s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              init_mode,
  output logic              write_enable,
  output logic [ADDR_W-1:0] init_address,
  output logic [31:0]       init_instruction,
  output logic              core_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  state_t          state, next_state;
  logic [ADDR_W:0] count, len_q;
  logic            short_q;
  logic            hs, start_ok, len_bad, last_word;
`ifdef IMEM_CHECKSUM_EN
  logic [31:0]     sum_q, exp_sum_q;
`endif

  // s_ready is registered and only high in LOAD, so hs can never fire elsewhere.
  assign hs        = s_valid & s_ready;
  assign len_bad   = (length == '0) || (length > (ADDR_W+1)'(DEPTH));
  assign last_word = (count == len_q - 1'b1);
  assign start_ok  = start && (state == IDLE || state == RUN || state == ERROR);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    case (state)
      IDLE, RUN, ERROR: if (start) next_state = len_bad ? ERROR : LOAD;
      LOAD:             if (hs && (last_word || s_last)) next_state = FLUSH;
`ifdef IMEM_CHECKSUM_EN
      FLUSH:            next_state = short_q ? ERROR : CHECK;
      CHECK:            next_state = (sum_q == exp_sum_q) ? RUN : ERROR;
`else
      FLUSH:            next_state = short_q ? ERROR : RUN;
`endif
      default:          next_state = ERROR;
    endcase
  end

  // Outputs are decoded from next_state and registered, so each one changes on the state edge.
  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      count            <= '0;
      len_q            <= '0;
      short_q          <= 1'b0;
      s_ready          <= 1'b0;
      init_mode        <= 1'b1;
      core_reset       <= 1'b1;
      write_enable     <= 1'b0;
      init_address     <= '0;
      init_instruction <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      error            <= 1'b0;
    end else begin
      state        <= next_state;
      write_enable <= hs;
      s_ready      <= (next_state == LOAD);
      busy         <= (next_state inside {LOAD, FLUSH, CHECK});
      done         <= (next_state == RUN);
      error        <= (next_state == ERROR);
      init_mode    <= (next_state != RUN);
      core_reset   <= (next_state != RUN);
      if (start_ok && !len_bad) begin
        count   <= '0;
        len_q   <= length;
        short_q <= 1'b0;
      end
      if (hs) begin
        init_address     <= count[ADDR_W-1:0];
        init_instruction <= s_data;
        count            <= count + 1'b1;
        // A short image still gets its final word written; FLUSH then routes to ERROR.
        short_q          <= s_last && !last_word;
      end
    end
  end

`ifdef IMEM_CHECKSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q     <= '0;
      exp_sum_q <= '0;
    end else if (start_ok) begin
      sum_q     <= '0;
      exp_sum_q <= expected_sum;
    end else if (hs) begin
      sum_q     <= sum_q + s_data;
    end
  end
`endif

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: scoreboard of expected imem writes plus status checks.
// Define IMEM_CHECKSUM_EN to also exercise the checksum path.
module tb_imem_boot_loader;
  import imem_boot_pkg::*;

  localparam int ADDR_W = 12;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W:0]   length;
  logic              s_valid;
  logic [31:0]       s_data;
  logic              s_last;
  logic              s_ready;
  logic              init_mode;
  logic              write_enable;
  logic [ADDR_W-1:0] init_address;
  logic [31:0]       init_instruction;
  logic              core_reset;
  logic              busy;
  logic              done;
  logic              error;
`ifdef IMEM_CHECKSUM_EN
  logic [31:0]       expected_sum;
`endif

  int          n_checks = 0;
  int          n_errors = 0;
  wr_t         exp_q[$];
  wr_t         mon_e;
  int unsigned next_addr;
  logic [31:0] pc_model;
  bit          got_done;

  imem_boot_loader #(.ADDR_W(ADDR_W), .DEPTH(IMEM_DEPTH)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .length           (length),
`ifdef IMEM_CHECKSUM_EN
    .expected_sum     (expected_sum),
`endif
    .s_valid          (s_valid),
    .s_data           (s_data),
    .s_last           (s_last),
    .s_ready          (s_ready),
    .init_mode        (init_mode),
    .write_enable     (write_enable),
    .init_address     (init_address),
    .init_instruction (init_instruction),
    .core_reset       (core_reset),
    .busy             (busy),
    .done             (done),
    .error            (error)
  );

  always #5 clk = ~clk;

  // Minimal fetch-stage model: PC held at the boot vector while core_reset is high.
  always @(posedge clk) pc_model <= core_reset ? BOOT_PC : pc_model + 32'd4;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (!reset && write_enable) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", {20'b0, init_address}, 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", {20'b0, init_address}, {20'b0, mon_e.addr});
        check("wr_data", init_instruction, mon_e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int len, input logic [31:0] esum);
    start  = 1'b1;
    length = (ADDR_W+1)'(len);
`ifdef IMEM_CHECKSUM_EN
    expected_sum = esum;
`endif
    tick();
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] data, input logic last, input int gap);
    int n = 0;
    s_valid = 1'b0;
    repeat (gap) tick();
    s_valid = 1'b1;
    s_data  = data;
    s_last  = last;
    while (!s_ready && n < 50) begin
      tick();
      n++;
    end
    check("handshake_ready", {31'b0, s_ready}, 32'd1);
    if (s_ready) begin
      exp_q.push_back('{addr: ADDR_W'(next_addr), data: data});
      next_addr++;
    end
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_end(output bit gd);
    int n = 0;
    while (!done && !error && n < 20) begin
      tick();
      n++;
    end
    check("end_reached", {31'b0, done | error}, 32'd1);
    gd = done;
  endtask

  task automatic check_frozen(input string tag);
    check({tag, "_init_mode"},  {31'b0, init_mode},  32'd1);
    check({tag, "_core_reset"}, {31'b0, core_reset}, 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check_frozen(tag);
    check({tag, "_we"},    {31'b0, write_enable}, 32'd0);
    check({tag, "_addr"},  {20'b0, init_address}, 32'd0);
    check({tag, "_instr"}, init_instruction,      32'd0);
    check({tag, "_ready"}, {31'b0, s_ready},      32'd0);
    check({tag, "_busy"},  {31'b0, busy},         32'd0);
    check({tag, "_done"},  {31'b0, done},         32'd0);
    check({tag, "_error"}, {31'b0, error},        32'd0);
  endtask

  task automatic apply_reset();
    #1 reset = 1'b1;
    #1 check_reset_vals("rst");
    exp_q.delete();
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    length  = '0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
`ifdef IMEM_CHECKSUM_EN
    expected_sum = '0;
`endif
    #3 check_reset_vals("por");
    tick();
    tick();
    reset = 1'b0;
    tick();
    check_reset_vals("idle");

    // 1: four back-to-back words, release to RUN, fetch starts at the boot vector.
    next_addr = 0;
    do_start(4, 32'd0);
    check("t1_ready", {31'b0, s_ready}, 32'd1);
    check("t1_busy",  {31'b0, busy},    32'd1);
    check_frozen("t1_load");
    send_word(32'hA000_0000, 1'b0, 0);
    send_word(32'hA000_0001, 1'b0, 0);
    send_word(32'hA000_0002, 1'b0, 0);
    send_word(32'hA000_0003, 1'b1, 0);
    check("t1_flush_ready", {31'b0, s_ready}, 32'd0);
    check("t1_flush_busy",  {31'b0, busy},    32'd1);
    check("t1_flush_done",  {31'b0, done},    32'd0);
    check_frozen("t1_flush");
    tick();
    check("t1_done",       {31'b0, done},       32'd1);
    check("t1_init_mode",  {31'b0, init_mode},  32'd0);
    check("t1_core_reset", {31'b0, core_reset}, 32'd0);
    check("t1_busy_run",   {31'b0, busy},       32'd0);
    check("t1_pc0", pc_model, 32'h0040_0000);
    tick();
    check("t1_pc1", pc_model, 32'h0040_0004);
    check("t1_q_empty", exp_q.size(), 32'd0);
    // Stream traffic in RUN must be ignored; any strobe trips the monitor.
    s_valid = 1'b1;
    s_data  = 32'hDEAD_BEEF;
    repeat (3) tick();
    check("t1_run_ready", {31'b0, s_ready}, 32'd0);
    s_valid = 1'b0;

    // 2: reload from RUN with 2-cycle gaps between words.
    next_addr = 0;
    do_start(3, 32'd0);
    check_frozen("t2_reload");
    check("t2_done_clr", {31'b0, done},    32'd0);
    check("t2_ready",    {31'b0, s_ready}, 32'd1);
    send_word(32'hB000_0010, 1'b0, 2);
    send_word(32'hB000_0011, 1'b0, 2);
    send_word(32'hB000_0012, 1'b1, 2);
    wait_end(got_done);
    check("t2_done",  {31'b0, done},  32'd1);
    check("t2_error", {31'b0, error}, 32'd0);
    check("t2_q_empty", exp_q.size(), 32'd0);

    // 4a: zero length from RUN goes straight to ERROR without writes.
    do_start(0, 32'd0);
    check("t4_len0_error", {31'b0, error},   32'd1);
    check("t4_len0_done",  {31'b0, done},    32'd0);
    check("t4_len0_busy",  {31'b0, busy},    32'd0);
    check("t4_len0_ready", {31'b0, s_ready}, 32'd0);
    check_frozen("t4_len0");
    tick();
    tick();

    // Minimal legal image (length 1) leaves ERROR.
    next_addr = 0;
    do_start(1, 32'd0);
    check("t4_len1_busy",  {31'b0, busy},  32'd1);
    check("t4_len1_error", {31'b0, error}, 32'd0);
    send_word(32'h0000_1111, 1'b1, 0);
    wait_end(got_done);
    check("t4_len1_done", {31'b0, done}, 32'd1);

    // 4b: length just above capacity.
    do_start(4097, 32'd0);
    check("t4_len4097_error", {31'b0, error}, 32'd1);
    check("t4_len4097_busy",  {31'b0, busy},  32'd0);
    tick();

    // 3: short image, s_last on third of five words.
    next_addr = 0;
    do_start(5, 32'd0);
    check("t3_busy", {31'b0, busy}, 32'd1);
    send_word(32'hC000_0000, 1'b0, 0);
    send_word(32'hC000_0001, 1'b0, 0);
    send_word(32'hC000_0002, 1'b1, 0);
    check("t3_flush_error", {31'b0, error}, 32'd0);
    wait_end(got_done);
    check("t3_error", {31'b0, error},        32'd1);
    check("t3_done",  {31'b0, done},         32'd0);
    check("t3_we",    {31'b0, write_enable}, 32'd0);
    check("t3_ready", {31'b0, s_ready},      32'd0);
    check_frozen("t3");
    check("t3_q_empty", exp_q.size(), 32'd0);

    // 5: reset after 2 of 8 words; start during LOAD is ignored.
    next_addr = 0;
    do_start(8, 32'd0);
    send_word(32'hD000_0000, 1'b0, 0);
    do_start(0, 32'd0);
    check("t5_ign_busy",  {31'b0, busy},    32'd1);
    check("t5_ign_error", {31'b0, error},   32'd0);
    check("t5_ign_ready", {31'b0, s_ready}, 32'd1);
    send_word(32'hD000_0001, 1'b0, 0);
    tick();
    check("t5_q_empty", exp_q.size(), 32'd0);
    apply_reset();
    check("t5_idle_busy", {31'b0, busy}, 32'd0);

    // Full-capacity length is accepted.
    do_start(4096, 32'd0);
    check("depth_busy",  {31'b0, busy},  32'd1);
    check("depth_error", {31'b0, error}, 32'd0);
    apply_reset();

`ifdef IMEM_CHECKSUM_EN
    // 6: checksum match and mismatch.
    next_addr = 0;
    do_start(3, 32'd6);
    send_word(32'd1, 1'b0, 0);
    send_word(32'd2, 1'b0, 0);
    send_word(32'd3, 1'b1, 0);
    wait_end(got_done);
    check("t6_match_done", {31'b0, done}, 32'd1);
    next_addr = 0;
    do_start(3, 32'd7);
    send_word(32'd1, 1'b0, 0);
    send_word(32'd2, 1'b0, 0);
    send_word(32'd3, 1'b1, 0);
    wait_end(got_done);
    check("t6_mismatch_error", {31'b0, error}, 32'd1);
    check("t6_mismatch_done",  {31'b0, done},  32'd0);
`endif

    tick();
    check("final_q_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
